// File: rtl/arbiter_4_deq.sv
// arbiter_4_deq: output-side arbiter of a ring node.
// Drains four flit FIFOs (0 pass_req, 1 pass_rep, 2 local_out_req,
// 3 local_out_rep) onto one outgoing link through a registered output stage.
// Round-robin per message: a winning head locks the link until its tail.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   flit_*/ctrl_*/vld_*           head-of-FIFO flit, ctrl, not-empty per source
//   deq_*                         combinational pop strobes, at most one high
//   out_ready                     downstream can take a flit this cycle
//   flit_out/ctrl_out/out_valid   registered output flit
//   err_pulse                     one-cycle pulse when a bad flit is discarded

// Per-source lane: eligibility for the scan and decode of its pop strobe.
module arbiter_4_deq_lane #(
  parameter logic [1:0] IDX = 2'd0
) (
  input  logic       vld,
  input  logic       locked,
  input  logic [1:0] gnt,
  input  logic       pop,
  input  logic [1:0] sel,
  output logic       elig,
  output logic       deq
);
  // While locked only the granted source may compete.
  assign elig = vld && (!locked || gnt == IDX);
  assign deq  = pop && sel == IDX;
endmodule

module arbiter_4_deq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] flit_pass_req,
  input  logic [15:0] flit_pass_rep,
  input  logic [15:0] flit_local_out_req,
  input  logic [15:0] flit_local_out_rep,
  input  logic [1:0]  ctrl_pass_req,
  input  logic [1:0]  ctrl_pass_rep,
  input  logic [1:0]  ctrl_local_out_req,
  input  logic [1:0]  ctrl_local_out_rep,
  input  logic        vld_pass_req,
  input  logic        vld_pass_rep,
  input  logic        vld_local_out_req,
  input  logic        vld_local_out_rep,
  output logic        deq_pass_req,
  output logic        deq_pass_rep,
  output logic        deq_local_out_req,
  output logic        deq_local_out_rep,
  input  logic        out_ready,
  output logic [15:0] flit_out,
  output logic [1:0]  ctrl_out,
  output logic        out_valid,
  output logic        err_pulse
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 16;
  localparam int CTRL_W    = 2;

  localparam logic [1:0] C_HEAD = 2'b01;
  localparam logic [1:0] C_TAIL = 2'b11;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t state, state_nxt;
  logic [1:0] gnt, gnt_nxt;
  logic [1:0] rr, rr_nxt;

  logic [NUM_LANES-1:0][VEC_W-1:0]  lane_flit;
  logic [NUM_LANES-1:0][CTRL_W-1:0] lane_ctrl;
  logic [NUM_LANES-1:0]             lane_vld;
  logic [NUM_LANES-1:0]             lane_elig;
  logic [NUM_LANES-1:0]             lane_deq;

  logic              locked;
  logic              found;
  logic [1:0]        sel;
  logic              slot_free;
  logic              pop;
  logic              fwd;
  logic              err;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [VEC_W-1:0]  sel_flit;

  assign lane_flit = {flit_local_out_rep, flit_local_out_req, flit_pass_rep, flit_pass_req};
  assign lane_ctrl = {ctrl_local_out_rep, ctrl_local_out_req, ctrl_pass_rep, ctrl_pass_req};
  assign lane_vld  = {vld_local_out_rep, vld_local_out_req, vld_pass_rep, vld_pass_req};

  assign deq_pass_req      = lane_deq[0];
  assign deq_pass_rep      = lane_deq[1];
  assign deq_local_out_req = lane_deq[2];
  assign deq_local_out_rep = lane_deq[3];

  assign locked    = (state == S_LOCKED);
  assign slot_free = !out_valid || out_ready;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      arbiter_4_deq_lane #(.IDX(2'(g))) u_lane (
        .vld    (lane_vld[g]),
        .locked (locked),
        .gnt    (gnt),
        .pop    (pop),
        .sel    (sel),
        .elig   (lane_elig[g]),
        .deq    (lane_deq[g])
      );
    end
  endgenerate

  // Rotating scan from rr; while locked only lane gnt is eligible, so the
  // same scan returns gnt or nothing.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    sel   = rr;
    idx   = rr;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = rr + 2'(k);
      if (!found && lane_elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign sel_ctrl = lane_ctrl[sel];
  assign sel_flit = lane_flit[sel];

  // Pop/forward/error decode. Idle forwards head or single (ctrl[0]=1);
  // locked forwards body or tail (ctrl[1]=1). Anything else is discarded.
  always_comb begin
    pop = found && slot_free && !rst;
    fwd = 1'b0;
    if (pop) fwd = locked ? sel_ctrl[1] : sel_ctrl[0];
    err = pop && !fwd;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gnt   <= 2'd0;
      rr    <= 2'd0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      rr    <= rr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr;
    if (fwd) begin
      case (state)
        S_IDLE: begin
          if (sel_ctrl == C_HEAD) begin
            state_nxt = S_LOCKED;
            gnt_nxt   = sel;
          end else if (sel_ctrl == C_TAIL) begin
            rr_nxt = sel + 2'd1;
          end
        end
        S_LOCKED: begin
          if (sel_ctrl == C_TAIL) begin
            state_nxt = S_IDLE;
            rr_nxt    = gnt + 2'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output stage: load on forward, otherwise drain when accepted. Data is
  // left untouched when the valid clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      flit_out  <= '0;
      ctrl_out  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err;
      if (fwd) begin
        out_valid <= 1'b1;
        flit_out  <= sel_flit;
        ctrl_out  <= sel_ctrl;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_arbiter_4_deq.sv
module tb_arbiter_4_deq;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fi [4];
  logic [1:0]  ci [4];
  logic [3:0]  vi;
  logic        out_ready;
  logic        deq_pass_req, deq_pass_rep, deq_local_out_req, deq_local_out_rep;
  logic [15:0] flit_out;
  logic [1:0]  ctrl_out;
  logic        out_valid, err_pulse;
  logic [3:0]  deq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign deq = {deq_local_out_rep, deq_local_out_req, deq_pass_rep, deq_pass_req};

  arbiter_4_deq dut (
    .clk(clk), .rst(rst),
    .flit_pass_req(fi[0]), .flit_pass_rep(fi[1]),
    .flit_local_out_req(fi[2]), .flit_local_out_rep(fi[3]),
    .ctrl_pass_req(ci[0]), .ctrl_pass_rep(ci[1]),
    .ctrl_local_out_req(ci[2]), .ctrl_local_out_rep(ci[3]),
    .vld_pass_req(vi[0]), .vld_pass_rep(vi[1]),
    .vld_local_out_req(vi[2]), .vld_local_out_rep(vi[3]),
    .deq_pass_req(deq_pass_req), .deq_pass_rep(deq_pass_rep),
    .deq_local_out_req(deq_local_out_req), .deq_local_out_rep(deq_local_out_rep),
    .out_ready(out_ready), .flit_out(flit_out), .ctrl_out(ctrl_out),
    .out_valid(out_valid), .err_pulse(err_pulse)
  );

  // Advance one clock; leaves time 1 unit past the rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [15:0] f, input logic [1:0] c);
    vi[s] = v; fi[s] = f; ci[s] = c;
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < 4; s++) set_src(s, 1'b0, 16'h0, 2'b00);
  endtask

  task automatic do_reset();
    clear_srcs(); out_ready = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_srcs(); out_ready = 1'b1; rst = 1'b1;
    set_src(0, 1'b1, 16'h00AA, 2'b01);
    #1;
    checks++; if (deq !== 4'b0000) begin failures++; $display("FAIL reset_deq got=%b exp=0000", deq); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (flit_out !== 16'h0000) begin failures++; $display("FAIL reset_flit got=%h exp=0000", flit_out); end
    checks++; if (ctrl_out !== 2'b00) begin failures++; $display("FAIL reset_ctrl got=%b exp=00", ctrl_out); end
    checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_pulse); end
    rst = 1'b0; clear_srcs();
  endtask

  task automatic test_single();
    logic [15:0] ef [3];
    logic [1:0]  ec [3];
    ef[0] = 16'h0001; ef[1] = 16'h0002; ef[2] = 16'h0003;
    ec[0] = 2'b01;    ec[1] = 2'b10;    ec[2] = 2'b11;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_src(0, 1'b1, ef[i], ec[i]);
      #1;
      checks++; if (deq !== 4'b0001) begin failures++; $display("FAIL single_deq[%0d] got=%b exp=0001", i, deq); end
      tick();
      checks++; if ({out_valid, ctrl_out, flit_out} !== {1'b1, ec[i], ef[i]})
        begin failures++; $display("FAIL single_out[%0d] got=%b/%b/%h exp=1/%b/%h", i, out_valid, ctrl_out, flit_out, ec[i], ef[i]); end
    end
    clear_srcs();
    #1;
    checks++; if (deq !== 4'b0000) begin failures++; $display("FAIL single_idle_deq got=%b exp=0000", deq); end
    tick();
    checks++; if (out_valid !== 1'b0 || flit_out !== 16'h0003) begin failures++; $display("FAIL single_drain got=%b/%h exp=0/0003", out_valid, flit_out); end
    // rr is now 1: pass_rep wins over pass_req.
    set_src(0, 1'b1, 16'h00AA, 2'b11);
    set_src(1, 1'b1, 16'h00BB, 2'b11);
    #1;
    checks++; if (deq !== 4'b0010) begin failures++; $display("FAIL single_rr1 got=%b exp=0010", deq); end
    tick();
    checks++; if (flit_out !== 16'h00BB) begin failures++; $display("FAIL single_rr1_flit got=%h exp=00bb", flit_out); end
    // rr is now 2: scan 2,3,0 finds pass_req.
    set_src(1, 1'b0, 16'h0, 2'b00);
    #1;
    checks++; if (deq !== 4'b0001) begin failures++; $display("FAIL single_rr2 got=%b exp=0001", deq); end
    tick();
    checks++; if (flit_out !== 16'h00AA || ctrl_out !== 2'b11) begin failures++; $display("FAIL single_rr2_flit got=%h/%b exp=00aa/11", flit_out, ctrl_out); end
    clear_srcs();
  endtask

  task automatic test_round_robin();
    int p [4];
    int lim [4];
    int es [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [15:0] xf;
    logic [1:0]  xc;
    do_reset();
    for (int s = 0; s < 4; s++) begin p[s] = 0; lim[s] = 2; end
    lim[0] = 4;
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 4; s++)
        set_src(s, p[s] < lim[s], 16'h1000 | 16'(s << 8) | 16'(p[s]), (p[s] % 2 == 0) ? 2'b01 : 2'b11);
      xf = 16'h1000 | 16'(es[i] << 8) | 16'(p[es[i]]);
      xc = (p[es[i]] % 2 == 0) ? 2'b01 : 2'b11;
      #1;
      checks++; if (deq !== 4'(1 << es[i])) begin failures++; $display("FAIL rr_deq[%0d] got=%b exp=%b", i, deq, 4'(1 << es[i])); end
      tick();
      checks++; if ({out_valid, ctrl_out, flit_out} !== {1'b1, xc, xf})
        begin failures++; $display("FAIL rr_out[%0d] got=%b/%b/%h exp=1/%b/%h", i, out_valid, ctrl_out, flit_out, xc, xf); end
      p[es[i]]++;
    end
    clear_srcs();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_src(0, 1'b1, 16'h0001, 2'b01);
    tick();
    set_src(0, 1'b1, 16'h0002, 2'b10);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (deq !== 4'b0000) begin failures++; $display("FAIL bp_deq[%0d] got=%b exp=0000", i, deq); end
      tick();
      checks++; if ({out_valid, ctrl_out, flit_out} !== {1'b1, 2'b01, 16'h0001})
        begin failures++; $display("FAIL bp_hold[%0d] got=%b/%b/%h exp=1/01/0001", i, out_valid, ctrl_out, flit_out); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (deq !== 4'b0001) begin failures++; $display("FAIL bp_resume_deq got=%b exp=0001", deq); end
    tick();
    checks++; if (flit_out !== 16'h0002 || ctrl_out !== 2'b10) begin failures++; $display("FAIL bp_resume got=%h/%b exp=0002/10", flit_out, ctrl_out); end
    set_src(0, 1'b1, 16'h0003, 2'b11);
    tick();
    checks++; if (flit_out !== 16'h0003 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_tail got=%h/%b exp=0003/1", flit_out, out_valid); end
    clear_srcs();
  endtask

  task automatic test_starved_lock();
    do_reset();
    set_src(1, 1'b1, 16'h4320, 2'b01);
    set_src(2, 1'b1, 16'h5000, 2'b01);
    #1;
    checks++; if (deq !== 4'b0010) begin failures++; $display("FAIL starve_head got=%b exp=0010", deq); end
    tick();
    set_src(1, 1'b0, 16'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (deq !== 4'b0000) begin failures++; $display("FAIL starve_block[%0d] got=%b exp=0000", i, deq); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL starve_drain got=%b exp=0", out_valid); end
    set_src(1, 1'b1, 16'h4321, 2'b11);
    #1;
    checks++; if (deq !== 4'b0010) begin failures++; $display("FAIL starve_tail_deq got=%b exp=0010", deq); end
    tick();
    checks++; if (flit_out !== 16'h4321 || ctrl_out !== 2'b11) begin failures++; $display("FAIL starve_tail got=%h/%b exp=4321/11", flit_out, ctrl_out); end
    set_src(1, 1'b0, 16'h0, 2'b00);
    #1;
    checks++; if (deq !== 4'b0100) begin failures++; $display("FAIL starve_next got=%b exp=0100", deq); end
    tick();
    checks++; if (flit_out !== 16'h5000) begin failures++; $display("FAIL starve_next_flit got=%h exp=5000", flit_out); end
    clear_srcs();
  endtask

  task automatic test_protocol_error();
    do_reset();
    set_src(3, 1'b1, 16'h1234, 2'b10);
    #1;
    checks++; if (deq !== 4'b1000) begin failures++; $display("FAIL err_idle_deq got=%b exp=1000", deq); end
    tick();
    checks++; if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL err_idle got=%b/%b exp=1/0", err_pulse, out_valid); end
    set_src(3, 1'b0, 16'h0, 2'b00);
    tick();
    checks++; if (err_pulse !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL err_idle_after got=%b/%b exp=0/0", err_pulse, out_valid); end
    // A new head inside a message is dropped while the lock is kept.
    set_src(0, 1'b1, 16'h0008, 2'b01);
    tick();
    set_src(0, 1'b1, 16'h0009, 2'b01);
    set_src(1, 1'b1, 16'h0777, 2'b11);
    #1;
    checks++; if (deq !== 4'b0001) begin failures++; $display("FAIL err_lock_deq got=%b exp=0001", deq); end
    tick();
    checks++; if (err_pulse !== 1'b1 || out_valid !== 1'b0 || flit_out !== 16'h0008)
      begin failures++; $display("FAIL err_lock got=%b/%b/%h exp=1/0/0008", err_pulse, out_valid, flit_out); end
    set_src(0, 1'b1, 16'h000A, 2'b11);
    #1;
    checks++; if (deq !== 4'b0001) begin failures++; $display("FAIL err_lock_tail_deq got=%b exp=0001", deq); end
    tick();
    checks++; if (flit_out !== 16'h000A || err_pulse !== 1'b0) begin failures++; $display("FAIL err_lock_tail got=%h/%b exp=000a/0", flit_out, err_pulse); end
    clear_srcs();
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    set_src(0, 1'b1, 16'h0001, 2'b01);
    tick();
    set_src(0, 1'b1, 16'h0002, 2'b10);
    rst = 1'b1;
    #1;
    checks++; if (deq !== 4'b0000) begin failures++; $display("FAIL rstmid_deq got=%b exp=0000", deq); end
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    set_src(0, 1'b0, 16'h0, 2'b00);
    set_src(2, 1'b1, 16'h7000, 2'b01);
    #1;
    checks++; if (deq !== 4'b0100) begin failures++; $display("FAIL rstmid_new_deq got=%b exp=0100", deq); end
    tick();
    checks++; if ({out_valid, ctrl_out, flit_out} !== {1'b1, 2'b01, 16'h7000})
      begin failures++; $display("FAIL rstmid_new got=%b/%b/%h exp=1/01/7000", out_valid, ctrl_out, flit_out); end
    clear_srcs();
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin fi[s] = 16'h0; ci[s] = 2'b00; end
    vi = 4'b0000;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_starved_lock();
    test_protocol_error();
    test_reset_mid_message();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
